// File: rtl/time_counter_core.sv
// Hours/minutes/seconds timekeeping datapath, stepped by rising edges of an asynchronous tick level.
// Define TIME_COUNTER_BCD_EN for packed-BCD fields; the default build counts in plain binary.
module time_counter_core #(
    parameter int HOURS_MAX   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        start,
    input  logic        set_minute,
    input  logic        set_ore,
    output logic [15:0] data_out,
    output logic [7:0]  hours_out,
    output logic        carry_hour,
    output logic        day_wrap,
    output logic [1:0]  mode
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } mode_e;

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

`ifdef TIME_COUNTER_BCD_EN
    localparam logic [7:0] SM_MAX = 8'h59;
    localparam logic [7:0] HR_MAX = 8'((((HOURS_MAX - 1) / 10) * 16) + ((HOURS_MAX - 1) % 10));
`else
    localparam logic [7:0] SM_MAX = 8'd59;
    localparam logic [7:0] HR_MAX = 8'(HOURS_MAX - 1);
`endif

    // Next value of one field, wrapping to zero after its maximum.
    function automatic logic [7:0] field_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v) begin
            return 8'd0;
        end
`ifdef TIME_COUNTER_BCD_EN
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
`else
        return v + 8'd1;
`endif
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic [PW-1:0]          prime_q, prime_d;
    logic                   primed;
    logic                   inc;

    mode_e                  mode_q, mode_d;
    logic [7:0]             sec_q, sec_d;
    logic [7:0]             min_q, min_d;
    logic [7:0]             hr_q, hr_d;
    logic                   carry_q, carry_d;
    logic                   wrap_q, wrap_d;

    assign primed  = (prime_q == PW'(PRIME_CYCLES));
    assign prime_d = primed ? prime_q : prime_q + PW'(1);
    assign inc     = sync_q[SYNC_STAGES-1] & ~sync_prev_q & primed;

    // State register (synchronous reset; all state is plain flops, no memories).
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            prime_q     <= '0;
            mode_q      <= IDLE;
            sec_q       <= 8'd0;
            min_q       <= 8'd0;
            hr_q        <= 8'd0;
            carry_q     <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            prime_q     <= prime_d;
            mode_q      <= mode_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            carry_q     <= carry_d;
            wrap_q      <= wrap_d;
        end
    end

    // Next-state decode: set requests outrank run enable.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mode_d = IDLE;
        if (set_minute) begin
            mode_d = SET_MIN;
        end else if (set_ore) begin
            mode_d = SET_HOUR;
        end else if (start) begin
            mode_d = RUN;
        end
    end

    // Counter update acts on the registered (previous-cycle) mode.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        carry_d = 1'b0;
        wrap_d  = 1'b0;
        if (inc) begin
            case (mode_q)
                RUN: begin
                    sec_d = field_inc(sec_q, SM_MAX);
                    if (sec_q == SM_MAX) begin
                        min_d = field_inc(min_q, SM_MAX);
                        if (min_q == SM_MAX) begin
                            carry_d = 1'b1;
                            hr_d    = field_inc(hr_q, HR_MAX);
                            wrap_d  = (hr_q == HR_MAX);
                        end
                    end
                end
                SET_MIN:  min_d = field_inc(min_q, SM_MAX);
                SET_HOUR: hr_d  = field_inc(hr_q, HR_MAX);
                default:  ;
            endcase
        end
        // Entering minute-set mode zeroes seconds, overriding any same-cycle increment.
        if (mode_d == SET_MIN && mode_q != SET_MIN) begin
            sec_d = 8'd0;
        end
    end

    // Output decode.
    always_comb begin
        data_out   = {min_q, sec_q};
        hours_out  = hr_q;
        carry_hour = carry_q;
        day_wrap   = wrap_q;
        mode       = mode_q;
    end

endmodule

// File: tb/tb_time_counter_core.sv
// Self-checking bench for time_counter_core: directed scenarios plus random mode/tick sequences
// checked against an integer hours/minutes/seconds reference model.
module tb_time_counter_core;

    localparam int HM = 24;
    localparam int SS = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        start;
    logic        set_minute;
    logic        set_ore;
    logic [15:0] data_out;
    logic [7:0]  hours_out;
    logic        carry_hour;
    logic        day_wrap;
    logic [1:0]  mode;

    int passed = 0;
    int total  = 0;

    // Reference model: plain integer time of day and the expected mode.
    int mh = 0, mm = 0, ms = 0;
    int cur_mode = 0;

    time_counter_core #(.HOURS_MAX(HM), .SYNC_STAGES(SS)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_in    (tick_in),
        .start      (start),
        .set_minute (set_minute),
        .set_ore    (set_ore),
        .data_out   (data_out),
        .hours_out  (hours_out),
        .carry_hour (carry_hour),
        .day_wrap   (day_wrap),
        .mode       (mode)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] enc(input int v);
`ifdef TIME_COUNTER_BCD_EN
        return 8'(((v / 10) * 16) + (v % 10));
`else
        return 8'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_data"}, 32'(data_out), {16'd0, enc(mm), enc(ms)});
        chk({tag, "_hours"}, 32'(hours_out), 32'(enc(mh)));
        chk({tag, "_mode"}, 32'(mode), 32'(cur_mode));
    endtask

    // One tick as seen by the timekeeping rules, given the mode in force.
    task automatic model_tick(output int ec, output int ew);
        ec = 0;
        ew = 0;
        case (cur_mode)
            1: begin
                ms = ms + 1;
                if (ms == 60) begin
                    ms = 0;
                    mm = mm + 1;
                    if (mm == 60) begin
                        mm = 0;
                        ec = 1;
                        mh = mh + 1;
                        if (mh == HM) begin
                            mh = 0;
                            ew = 1;
                        end
                    end
                end
            end
            2: mm = (mm + 1) % 60;
            3: mh = (mh + 1) % HM;
            default: ;
        endcase
    endtask

    task automatic set_ctrl(input logic sm, input logic so, input logic st);
        int nm;
        @(negedge clock);
        set_minute = sm;
        set_ore    = so;
        start      = st;
        nm = sm ? 2 : (so ? 3 : (st ? 1 : 0));
        if (nm == 2 && cur_mode != 2) ms = 0;
        cur_mode = nm;
        repeat (2) @(negedge clock);
        check_state("set_ctrl");
    endtask

    // Tick high for 3 clocks then low for 3, counting pulse cycles over the window.
    task automatic do_tick(input string tag);
        int cc, wc, ec, ew;
        cc = 0;
        wc = 0;
        @(negedge clock);
        tick_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            cc += int'(carry_hour);
            wc += int'(day_wrap);
            if (i == 2) tick_in = 1'b0;
        end
        model_tick(ec, ew);
        check_state(tag);
        chk({tag, "_carry"}, 32'(cc), 32'(ec));
        chk({tag, "_wrap"}, 32'(wc), 32'(ew));
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) do_tick(tag);
    endtask

    initial begin
        reset      = 1'b1;
        tick_in    = 1'b1;
        start      = 1'b1;
        set_minute = 1'b0;
        set_ore    = 1'b0;
        repeat (3) @(negedge clock);
        check_state("reset");
        chk("reset_carry", 32'(carry_hour), 32'd0);
        chk("reset_wrap", 32'(day_wrap), 32'd0);

        // Release with tick_in already high: priming must swallow it.
        reset = 1'b0;
        cur_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("prime_hold", 32'(data_out), 32'd0);
        end
        chk("prime_mode", 32'(mode), 32'd1);
        tick_in = 1'b0;
        repeat (4) @(negedge clock);

        // First genuine rise lands SYNC_STAGES+1 edges later.
        tick_in = 1'b1;
        for (int i = 1; i <= SS + 1; i++) begin
            @(negedge clock);
            chk("latency", 32'(data_out[7:0]), (i == SS + 1) ? 32'(enc(1)) : 32'd0);
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clock);
        ms = 1;
        check_state("first_tick");

        // Preload 23:59:58 through set modes and run.
        set_ctrl(1'b0, 1'b1, 1'b0);
        ticks(23, "preload_hr");
        set_ctrl(1'b1, 1'b0, 1'b0);
        ticks(59, "preload_min");
        set_ctrl(1'b0, 1'b0, 1'b1);
        ticks(58, "preload_sec");
        do_tick("to_235959");
        do_tick("day_rollover");

        // Minute-set entry clears seconds; minute wrap does not carry.
        set_ctrl(1'b1, 1'b0, 1'b0);
        ticks(59, "sm_setup_min");
        set_ctrl(1'b0, 1'b0, 1'b1);
        ticks(42, "sm_setup_sec");
        set_ctrl(1'b1, 1'b0, 1'b0);
        do_tick("sm_min_wrap");

        // set_minute outranks set_ore, then hour-set.
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_ctrl(1'b1, 1'b1, 1'b0);
        ticks(3, "both_set");
        set_ctrl(1'b0, 1'b1, 1'b0);
        ticks(2, "hour_set");

        // Random mode requests and tick bursts.
        for (int it = 0; it < 30; it++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 7));
            set_ctrl(r[2], r[1], r[0]);
            ticks($urandom_range(0, 3), "random");
        end

        // Idle holds everything.
        set_ctrl(1'b0, 1'b0, 1'b0);
        ticks(5, "idle_hold");

        // Preload 12:34:56 and reset with an increment pending.
        set_ctrl(1'b0, 1'b1, 1'b0);
        ticks((12 - mh + HM) % HM, "to12_hr");
        set_ctrl(1'b1, 1'b0, 1'b0);
        ticks((34 - mm + 60) % 60, "to12_min");
        set_ctrl(1'b0, 1'b0, 1'b1);
        ticks(56, "to12_sec");
        @(negedge clock);
        tick_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mh = 0;
        mm = 0;
        ms = 0;
        cur_mode = 0;
        check_state("mid_reset");
        reset = 1'b0;
        cur_mode = 1;
        repeat (6) @(negedge clock);
        check_state("reprime");
        tick_in = 1'b0;
        repeat (3) @(negedge clock);
        do_tick("after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/time_counter_core.md
Name: time_counter_core

Overview:
Timekeeping datapath for the digital clock. It takes the control block's muxed clock (applied here as a level tick), set_minute, set_ore and start, and keeps hours, minutes and seconds counters. It drives data_out = {minutes, seconds}, which the control block decodes for the alarm (00:00 / 00:01), plus hours for the display.

Parameters:
HOURS_MAX, 24, hour modulus (24 or 12 supported); hours count 0..HOURS_MAX-1
SYNC_STAGES, 2, synchronizer depth for tick_in (min 2)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high
tick_in  input  1  muxed clock from control block, asynchronous level; each rising edge = one increment
start  input  1  run enable (1 = clock running)
set_minute  input  1  minute-set mode request
set_ore  input  1  hour-set mode request
data_out  output  16  [15:8] minutes, [7:0] seconds
hours_out  output  8  hours
carry_hour  output  1  one-cycle pulse on minute wrap 59->0 in RUN
day_wrap  output  1  one-cycle pulse on hour wrap in RUN
mode  output  2  registered state: 0 IDLE, 1 RUN, 2 SET_MIN, 3 SET_HOUR

Behaviour:
- Reset: data_out=0, hours_out=0, carry_hour=0, day_wrap=0, mode=IDLE, synchronizer and edge history=0, prime counter=0.
- Synchronizer: tick_in passes through SYNC_STAGES flops. Edge pulse inc = sync_out & ~sync_prev.
- Latency: tick_in rise to counter update = SYNC_STAGES+1 clock cycles.
- Priming: inc is suppressed for the first SYNC_STAGES+1 cycles after reset deasserts. A tick_in already high at reset release therefore gives no increment.
- tick_in highs shorter than one clock period may be missed. The bench keeps tick_in high/low for at least 2 clocks.
- Next-state decode, every cycle, in priority order: set_minute -> SET_MIN; else set_ore -> SET_HOUR; else start -> RUN; else IDLE. mode is the registered result.
- inc acts according to the registered mode, i.e. the mode of the previous cycle. If a mode change and inc land on the same cycle, the inc takes the old mode's action.
- IDLE: inc is ignored. Counters hold.
- RUN: seconds++.
  - seconds 59 -> 0, minutes++.
  - minutes 59 -> 0, carry_hour pulse, hours++.
  - hours HOURS_MAX-1 -> 0, day_wrap pulse.
  - All carries resolve in the same cycle; 23:59:59 -> 00:00:00 takes one cycle, and carry_hour and day_wrap pulse together.
- SET_MIN:
  - On the cycle mode enters SET_MIN, seconds clear to 0.
  - inc: minutes++, 59 -> 0, no carry into hours, no carry_hour pulse.
- SET_HOUR: inc: hours++, HOURS_MAX-1 -> 0, no day_wrap pulse. Seconds and minutes hold.
- Leaving a set mode keeps the values. RUN resumes from them on the next inc.
- Reset mid-operation: all state returns to reset values on the next clock edge regardless of inc or mode. Priming restarts.
- Widths: unused upper bits of each 8-bit field are always 0. Values >59 or >=HOURS_MAX are never produced.
- carry_hour and day_wrap are registered, high for exactly one cycle, and low otherwise.

Optional Feature:
TIME_COUNTER_BCD_EN
- Defined: each 8-bit field is packed BCD, [7:4] tens and [3:0] units.
  - The units digit wraps 9 -> 0 with a carry into tens.
  - Seconds/minutes max is 8'h59. Hours max is the BCD form of HOURS_MAX-1 (8'h23 for 24).
  - Alarm zero-detect is unaffected.
- Undefined: fields are plain binary. Seconds/minutes max is 8'h3B; hours max is HOURS_MAX-1 (8'h17).

Test Plan:
- Reset release with tick_in held high, start=1, 10 cycles -> data_out stays 16'h0000 and no increment occurs. First genuine tick_in rise updates seconds to 1 exactly SYNC_STAGES+1 cycles later.
- RUN, preload via set modes to 23:59:58 (binary), 2 ticks:
  - 1st tick -> data_out 16'h3B3B.
  - 2nd tick -> data_out 16'h0000, hours_out 0, carry_hour and day_wrap both high for one cycle.
- set_minute=1 with seconds=42, minutes=59; 1 tick:
  - Entry cycle clears seconds to 0.
  - Tick wraps minutes to 0, hours unchanged, carry_hour stays 0.
- set_minute=1 and set_ore=1 together, 3 ticks -> mode=2 and minutes +3, hours unchanged. Then drop set_minute -> mode=3, 2 ticks -> hours +2.
- start=0, no set, 5 ticks -> all outputs hold and mode=0. Assert reset mid-run at 12:34:56 -> all zero next cycle.
- TIME_COUNTER_BCD_EN defined: from 00:09 one tick -> data_out 16'h0010. From 00:59:59 one tick -> data_out 16'h0000, hours_out 8'h01.
